// File: rtl/lsu_stb_alloc_ctl.sv
// Store-buffer allocation controller for one thread: picks the write entry for
// each M-stage store, handles the one-cycle cancel window, and tracks issue/ack order.
module lsu_stb_alloc_ctl #(
  parameter int PTR_W = 3
) (
  input  logic                      rclk,
  input  logic                      rst,
  input  logic                      st_vld_m,
  input  logic                      st_cancel_w,
  input  logic                      pcx_grant,
  input  logic                      cpx_st_ack,
  output logic [(1<<PTR_W)-1:0]     stb_clk_en_l,
  output logic [PTR_W-1:0]          stb_wr_idx,
  output logic                      stb_issue_vld,
  output logic [PTR_W-1:0]          stb_issue_idx,
  output logic [(1<<PTR_W)-1:0]     stb_vld,
  output logic [PTR_W:0]            stb_cnt,
  output logic                      stb_full,
  output logic                      stb_empty,
  output logic                      stb_err
);

  localparam int DEPTH = 1 << PTR_W;

  logic [PTR_W:0]       wptr_q, wptr_d;
  logic [PTR_W:0]       iptr_q, iptr_d;
  logic [PTR_W:0]       aptr_q, aptr_d;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic                 err_q, err_d;
  logic                 lastAllocVld_q;
  logic [PTR_W-1:0]     lastAllocIdx_q;

  logic                 alloc;
  logic                 legalCancel;
  logic                 reuse;
  logic                 legalGrant;
  logic                 legalAck;
  logic [PTR_W-1:0]     target;

  // Occupancy comes purely from pointer distance so wrap never confuses full/empty.
  assign stb_cnt   = wptr_q - aptr_q;
  assign stb_full  = (stb_cnt == (PTR_W+1)'(DEPTH));
  assign stb_empty = (stb_cnt == '0);
  assign stb_vld   = vld_q;
  assign stb_err   = err_q;
  assign stb_wr_idx    = wptr_q[PTR_W-1:0];
  assign stb_issue_idx = iptr_q[PTR_W-1:0];

  // The newest entry is held back from PCX while it can still be cancelled.
  assign stb_issue_vld = (iptr_q != wptr_q) &&
                         !(lastAllocVld_q && (iptr_q[PTR_W-1:0] == lastAllocIdx_q));

  assign alloc       = st_vld_m & ~stb_full & ~rst;
  assign legalCancel = st_cancel_w & lastAllocVld_q;
  assign reuse       = alloc & legalCancel;
  assign legalGrant  = pcx_grant & stb_issue_vld;
  assign legalAck    = cpx_st_ack & (aptr_q != iptr_q);
  assign target      = reuse ? lastAllocIdx_q : wptr_q[PTR_W-1:0];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stb_clk_en_l[k] = ~(alloc && (target == PTR_W'(k)));
    end
  end

  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    iptr_d = iptr_q;
    aptr_d = aptr_q;
    if (legalAck) begin
      vld_d[aptr_q[PTR_W-1:0]] = 1'b0;
      aptr_d = aptr_q + 1'b1;
    end
    if (legalGrant) begin
      iptr_d = iptr_q + 1'b1;
    end
    // A cancel paired with a new store hands the same slot straight back.
    if (legalCancel && !reuse) begin
      vld_d[lastAllocIdx_q] = 1'b0;
      wptr_d = wptr_q - 1'b1;
    end
    if (alloc) begin
      vld_d[target] = 1'b1;
      if (!reuse) begin
        wptr_d = wptr_q + 1'b1;
      end
    end
  end

  assign err_d = err_q
               | (st_vld_m & stb_full)
               | (st_cancel_w & ~lastAllocVld_q)
               | (pcx_grant & ~stb_issue_vld)
               | (cpx_st_ack & (aptr_q == iptr_q));

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      iptr_q         <= '0;
      aptr_q         <= '0;
      vld_q          <= '0;
      err_q          <= 1'b0;
      lastAllocVld_q <= 1'b0;
      lastAllocIdx_q <= '0;
    end else begin
      wptr_q         <= wptr_d;
      iptr_q         <= iptr_d;
      aptr_q         <= aptr_d;
      vld_q          <= vld_d;
      err_q          <= err_d;
      lastAllocVld_q <= alloc;
      lastAllocIdx_q <= target;
    end
  end

endmodule

// File: tb/tb_lsu_stb_alloc_ctl.sv
// Self-checking bench for lsu_stb_alloc_ctl: an in-order entry-list model feeds
// a scoreboard queue of expected post-edge outputs.
module tb_lsu_stb_alloc_ctl;

  logic       rclk;
  logic       rst;
  logic       st_vld_m;
  logic       st_cancel_w;
  logic       pcx_grant;
  logic       cpx_st_ack;
  logic [7:0] stb_clk_en_l;
  logic [2:0] stb_wr_idx;
  logic       stb_issue_vld;
  logic [2:0] stb_issue_idx;
  logic [7:0] stb_vld;
  logic [3:0] stb_cnt;
  logic       stb_full;
  logic       stb_empty;
  logic       stb_err;

  typedef struct {
    logic [7:0] vld;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
    logic       issV;
    logic [2:0] issIdx;
    logic [2:0] wrIdx;
  } expT;

  expT        scoreQ[$];
  logic [2:0] entryQ[$];
  int         issuedCount;
  int         nextIdx;
  logic       mErr;
  logic       mLastVld;
  logic [2:0] mLastIdx;
  int         checkCount;
  int         errorCount;

  lsu_stb_alloc_ctl #(.PTR_W(3)) dut (
    .rclk(rclk), .rst(rst), .st_vld_m(st_vld_m), .st_cancel_w(st_cancel_w),
    .pcx_grant(pcx_grant), .cpx_st_ack(cpx_st_ack), .stb_clk_en_l(stb_clk_en_l),
    .stb_wr_idx(stb_wr_idx), .stb_issue_vld(stb_issue_vld), .stb_issue_idx(stb_issue_idx),
    .stb_vld(stb_vld), .stb_cnt(stb_cnt), .stb_full(stb_full), .stb_empty(stb_empty),
    .stb_err(stb_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic modelIssueVld();
    if (issuedCount >= entryQ.size()) return 1'b0;
    return !(mLastVld && entryQ[issuedCount] == mLastIdx);
  endfunction

  function automatic expT modelOutputs();
    expT e;
    int front;
    e.vld = 8'h00;
    foreach (entryQ[i]) e.vld[entryQ[i]] = 1'b1;
    e.cnt    = 4'(entryQ.size());
    e.full   = (entryQ.size() == 8);
    e.empty  = (entryQ.size() == 0);
    e.err    = mErr;
    e.issV   = modelIssueVld();
    front    = (entryQ.size() != 0) ? int'(entryQ[0]) : nextIdx;
    e.issIdx = 3'((front + issuedCount) % 8);
    e.wrIdx  = 3'(nextIdx);
    return e;
  endfunction

  task automatic modelReset();
    entryQ.delete();
    scoreQ.delete();
    issuedCount = 0;
    nextIdx     = 0;
    mErr        = 1'b0;
    mLastVld    = 1'b0;
    mLastIdx    = 3'd0;
  endtask

  task automatic compareAll(input expT e, input string ph);
    checkOutput({ph, ".vld"},    32'(stb_vld),       32'(e.vld));
    checkOutput({ph, ".cnt"},    32'(stb_cnt),       32'(e.cnt));
    checkOutput({ph, ".full"},   32'(stb_full),      32'(e.full));
    checkOutput({ph, ".empty"},  32'(stb_empty),     32'(e.empty));
    checkOutput({ph, ".err"},    32'(stb_err),       32'(e.err));
    checkOutput({ph, ".issV"},   32'(stb_issue_vld), 32'(e.issV));
    checkOutput({ph, ".issIdx"}, 32'(stb_issue_idx), 32'(e.issIdx));
    checkOutput({ph, ".wrIdx"},  32'(stb_wr_idx),    32'(e.wrIdx));
  endtask

  // One clock cycle: drive, check enables, advance the model, then compare post-edge state.
  task automatic applyStimulus(input logic v, input logic c, input logic g, input logic a);
    logic       full, alloc, legalCancel, reuse, issV, legalAck;
    logic [2:0] target;
    logic [7:0] expEn;
    expT        got;
    st_vld_m = v; st_cancel_w = c; pcx_grant = g; cpx_st_ack = a;
    #2;
    full        = (entryQ.size() == 8);
    alloc       = v && !full;
    legalCancel = c && mLastVld;
    reuse       = alloc && legalCancel;
    issV        = modelIssueVld();
    legalAck    = a && (issuedCount > 0);
    target      = reuse ? mLastIdx : 3'(nextIdx);
    expEn       = 8'hFF;
    if (alloc) expEn[target] = 1'b0;
    checkOutput("clk_en_l", 32'(stb_clk_en_l), 32'(expEn));

    if ((v && full) || (c && !mLastVld) || (g && !issV) || (a && issuedCount == 0)) mErr = 1'b1;
    if (legalAck) begin
      void'(entryQ.pop_front());
      issuedCount--;
    end
    if (g && issV) issuedCount++;
    if (legalCancel && !reuse) begin
      void'(entryQ.pop_back());
      nextIdx = (nextIdx + 7) % 8;
    end
    if (alloc && !reuse) begin
      entryQ.push_back(3'(nextIdx));
      nextIdx = (nextIdx + 1) % 8;
    end
    mLastVld = alloc;
    mLastIdx = target;
    scoreQ.push_back(modelOutputs());

    @(posedge rclk);
    #1;
    if (scoreQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = scoreQ.pop_front();
      compareAll(got, "post");
    end
  endtask

  task automatic doReset();
    st_vld_m = 0; st_cancel_w = 0; pcx_grant = 0; cpx_st_ack = 0;
    rst = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rst = 1'b0;
    modelReset();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    st_vld_m = 0; st_cancel_w = 0; pcx_grant = 0; cpx_st_ack = 0;
    modelReset();
    doReset();

    // Reset values and the single-store latency into PCX eligibility.
    compareAll(modelOutputs(), "reset");
    checkOutput("reset.clk_en_l", 32'(stb_clk_en_l), 32'h FF);
    applyStimulus(1, 0, 0, 0);
    checkOutput("first.issV_blocked", 32'(stb_issue_vld), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("first.issV", 32'(stb_issue_vld), 32'd1);
    checkOutput("first.issIdx", 32'(stb_issue_idx), 32'd0);

    // Fill to eight, then overflow.
    doReset();
    repeat (8) applyStimulus(1, 0, 0, 0);
    checkOutput("fill.full", 32'(stb_full), 32'd1);
    checkOutput("fill.vld", 32'(stb_vld), 32'hFF);
    applyStimulus(1, 0, 0, 0);
    checkOutput("overflow.err", 32'(stb_err), 32'd1);
    checkOutput("overflow.cnt", 32'(stb_cnt), 32'd8);

    // Cancel-and-reuse of entry 2, then a plain cancel and an illegal one.
    doReset();
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("reuse.cnt", 32'(stb_cnt), 32'd3);
    checkOutput("reuse.wrIdx", 32'(stb_wr_idx), 32'd3);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);

    // Full drain with wrap-around reuse of the low entries.
    doReset();
    repeat (8) applyStimulus(1, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 1, 0);
    repeat (8) applyStimulus(0, 0, 0, 1);
    checkOutput("drain.empty", 32'(stb_empty), 32'd1);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("wrap.cnt", 32'(stb_cnt), 32'd3);
    checkOutput("wrap.vld", 32'(stb_vld), 32'h07);
    checkOutput("wrap.err", 32'(stb_err), 32'd0);

    // Alloc against a full buffer while an ack frees a slot.
    doReset();
    repeat (8) applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("fullack.cnt", 32'(stb_cnt), 32'd7);
    checkOutput("fullack.err", 32'(stb_err), 32'd1);

    // Asynchronous reset in the middle of traffic.
    doReset();
    repeat (4) applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0);
    st_vld_m = 0; st_cancel_w = 0; pcx_grant = 0; cpx_st_ack = 0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    compareAll(modelOutputs(), "async");
    checkOutput("async.clk_en_l", 32'(stb_clk_en_l), 32'hFF);
    doReset();

    // Random mixed traffic, all four requests honoured independently.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 15),
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 40));
    end
    st_vld_m = 0; st_cancel_w = 0; pcx_grant = 0; cpx_st_ack = 0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/lsu_stb_alloc_ctl.md
Name: lsu_stb_alloc_ctl

Overview:
- Allocation and sequencing controller for one thread's store-buffer state array.
- Picks the entry each M-stage store is written into and drives the per-entry active-low write enables (stb_clk_en_l) that gate the entry state flops.
- Supports a one-cycle cancel window after each allocation.
- Tracks entries in order through three phases: written, issued to PCX, acknowledged by CPX.

Parameters:
PTR_W, 3, entry index width; DEPTH = 2**PTR_W entries (8 by default)

Ports:
rclk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
st_vld_m  in  1  store in M stage requests an entry
st_cancel_w  in  1  cancels the store allocated in the previous cycle
pcx_grant  in  1  PCX accepts the entry at the issue pointer
cpx_st_ack  in  1  oldest issued entry acknowledged; entry freed
stb_clk_en_l  out  DEPTH  per-entry write enable, active low, combinational
stb_wr_idx  out  PTR_W  entry index selected for the current allocation (wptr low bits)
stb_issue_vld  out  1  entry at the issue pointer is eligible for PCX
stb_issue_idx  out  PTR_W  issue-pointer entry index
stb_vld  out  DEPTH  per-entry occupied bits
stb_cnt  out  PTR_W+1  occupied entry count, 0..DEPTH
stb_full  out  1  stb_cnt == DEPTH
stb_empty  out  1  stb_cnt == 0
stb_err  out  1  sticky protocol-error flag

Behaviour:
- Pointers: wptr, iptr and aptr, each PTR_W+1 bits wide, with the MSB used as a wrap bit.
  - Invariant: aptr <= iptr <= wptr, modulo 2*DEPTH.
  - stb_cnt = wptr - aptr, computed in PTR_W+1 bit arithmetic.
- Reset:
  - Pointers = 0, stb_vld = 0, stb_cnt = 0, stb_empty = 1, stb_full = 0, stb_err = 0.
  - stb_clk_en_l = all ones; stb_issue_vld = 0.
  - Internal last_alloc_vld = 0, last_alloc_idx = 0.
  - Reset asserted mid-operation discards all entries immediately.
- Allocation:
  - alloc = st_vld_m & ~stb_full, where stb_full is the registered current state.
  - stb_clk_en_l[k] = ~(alloc & k == target), with target = wptr[PTR_W-1:0] in the same cycle, so the state flops capture on that edge.
  - Next cycle: stb_vld[target] = 1 and wptr++.
  - last_alloc_vld <= alloc; last_alloc_idx <= target.
- Allocation while full: dropped, no enable is asserted, and stb_err is set.
  - This applies even if cpx_st_ack arrives in the same cycle; full is evaluated on pre-edge state.
- Cancel:
  - A legal cancel requires st_cancel_w & last_alloc_vld. It clears stb_vld[last_alloc_idx] and decrements wptr.
  - st_cancel_w with last_alloc_vld = 0: ignored, sets stb_err.
  - Cancel and alloc in the same cycle: the cancelled slot is reused. target = last_alloc_idx, its enable is asserted, stb_vld stays 1, wptr is unchanged, and last_alloc_vld <= 1.
- Issue:
  - stb_issue_vld = (iptr != wptr) & ~(last_alloc_vld & iptr[PTR_W-1:0] == last_alloc_idx).
  - An entry therefore cannot issue in its cancel window; its earliest issue is 2 cycles after its enable pulse.
  - pcx_grant & stb_issue_vld: iptr++. pcx_grant without stb_issue_vld: ignored, sets stb_err.
- Ack:
  - cpx_st_ack & (aptr != iptr): clears stb_vld[aptr[PTR_W-1:0]] and increments aptr.
  - Ack with nothing issued: ignored, sets stb_err.
- Simultaneous events:
  - Alloc, grant, ack and cancel in one cycle are all honoured independently.
  - The next-state count equals cnt + alloc - legal_cancel - legal_ack, with the cancel+alloc reuse case contributing 0.
- Wrap-around: pointers wrap modulo 2*DEPTH. Full/empty are always derived from the count, never from index equality.
- stb_err clears only on rst.
- All outputs except stb_clk_en_l are registered or decoded from registered state.

Test Plan:
- Reset, then st_vld_m for 1 cycle:
  - stb_clk_en_l = 8'hFE during that cycle.
  - Next cycle: stb_vld = 8'h01, stb_cnt = 1, stb_issue_vld = 0.
  - One cycle later: stb_issue_vld = 1, stb_issue_idx = 0.
- 8 back-to-back allocations, then a 9th:
  - After the 8th: stb_full = 1, stb_vld = 8'hFF.
  - 9th: no enable, stb_err = 1, stb_cnt stays 8.
- Alloc to entry 2, then st_cancel_w plus st_vld_m in the next cycle:
  - stb_clk_en_l = 8'hFB again, wptr unchanged.
  - Following cycle: stb_cnt = 3, stb_issue_vld does not select entry 2.
- Fill 8, grant 8, ack 8, then allocate 3 more:
  - Entries 0, 1, 2 are reused, with wptr wrap bit = 1.
  - stb_empty = 1 before the new allocations; stb_cnt = 3 after.
- Full buffer, alloc + ack in the same cycle:
  - Alloc is rejected and stb_err = 1.
  - stb_cnt = 7 next cycle.
- 4 entries allocated, 2 granted, assert rst mid-stream:
  - All outputs return to reset values asynchronously, before the next rclk edge.
